motor_cmd_uart_master: RTL and testbench

Host-side end of the motor command UART link. Accepts per-motor move commands (divider, step count) from the sequencing logic, serialises each as a 5-byte frame to the motor CPLD through an `async_transmitter` instance, and decodes the motor CPLD's periodic 2-byte busy-status stream from an `async_receiver` instance. It maintains a 10-bit `pending` map so that no command is sent to a motor slot the far end has not yet freed.

---
 rtl/motor_cmd_uart_master.sv | 196 +++++++++++++++++++
 tb/tb_motor_cmd_uart_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_uart_master.sv
`default_nettype none
// ============================================================================
//  Module   : motor_cmd_uart_master
//  Purpose  : Host end of the motor command UART link. Serialises per-motor
//             move commands into 5-byte frames for an external transmitter
//             and decodes the motor CPLD's 2-byte busy-status stream into a
//             per-motor pending map with link supervision.
//  Revision : 1.0  initial release
// ============================================================================
module motor_cmd_uart_master #(
   parameter int GUARD_CYCLES = 2048,
   parameter int LINK_TIMEOUT = 600000
) (
   input  logic        CLK_SE_AR,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_motor,
   input  logic [14:0] cmd_divider,
   input  logic [12:0] cmd_steps,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   input  logic        rx_data_ready,
   input  logic [7:0]  rx_data,
   output logic [9:0]  pending,
   output logic        link_up,
   output logic        frame_sent,
   output logic        cmd_drop,
   output logic        rx_err
);

   localparam int GW = $clog2(GUARD_CYCLES + 1);
   localparam int TW = $clog2(LINK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   state_t        state;
   logic [31:0]   word;        // remaining payload bytes, next byte in [7:0]
   logic [2:0]    idx;         // index of the byte currently in flight
   logic          hi_cnt;      // WAIT_HI timeout for a transmitter that never raises busy
   logic [GW-1:0] guard_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [9:0]    status;      // far-end busy flags as last reported
   logic [9:0]    shadow;      // locally-set busy bits not yet confirmed by the far end
   logic [1:0]    seen;        // which status halves have arrived since link loss
   logic          rx_prev;

   logic [15:0]   pend_ext;
   logic          motor_ok;
   logic          accept;
   logic          rx_edge;
   logic          rx_bad;
   logic          rx_valid;
   logic [9:0]    half_mask;
   logic [9:0]    flags10;
   logic [9:0]    upd_mask;
   logic [9:0]    shadow_clr;
   logic [9:0]    shadow_set;
   logic [1:0]    seen_next;
   logic          timeout_hit;

   // Out-of-range motor numbers read as busy so indexing stays in bounds;
   // they are still accepted (and dropped) through the motor_ok term.
   assign pend_ext  = {6'h3f, pending};
   assign motor_ok  = (cmd_motor < 4'd10);
   assign cmd_ready = link_up & (state == IDLE) & (~motor_ok | ~pend_ext[cmd_motor]);
   assign accept    = cmd_valid & cmd_ready;

   assign rx_edge   = rx_data_ready & ~rx_prev;
   assign rx_bad    = (rx_data[6:5] != 2'b00);
   assign rx_valid  = rx_edge & ~rx_bad;
   assign half_mask = rx_data[7] ? 10'h3e0 : 10'h01f;
   assign flags10   = rx_data[7] ? {rx_data[4:0], 5'b00000} : {5'b00000, rx_data[4:0]};

   // While the guard runs, a status byte may predate our latest frame, so
   // bits we set locally keep their last status value and stay shadowed.
   assign upd_mask   = (guard_cnt != '0) ? (half_mask & ~shadow) : half_mask;
   assign shadow_clr = (rx_valid && (guard_cnt == '0)) ? half_mask : 10'h000;
   assign shadow_set = (accept && motor_ok) ? (10'h001 << cmd_motor) : 10'h000;

   assign seen_next   = seen | (rx_valid ? (rx_data[7] ? 2'b10 : 2'b01) : 2'b00);
   assign timeout_hit = ~rx_valid & (tmo_cnt == TW'(1));

   assign pending = status | shadow;

   // Transmit sequencer: latches a frame and walks its five bytes through the transmitter
   always_ff @(posedge CLK_SE_AR) begin
      if (rst) begin
         state      <= IDLE;
         word       <= '0;
         idx        <= '0;
         hi_cnt     <= 1'b0;
         tx_data    <= '0;
         tx_start   <= 1'b0;
         frame_sent <= 1'b0;
         cmd_drop   <= 1'b0;
         guard_cnt  <= '0;
      end else begin
         frame_sent <= 1'b0;
         cmd_drop   <= 1'b0;
         if (guard_cnt != '0)
            guard_cnt <= guard_cnt - 1'b1;

         case (state)
            IDLE: begin
               if (accept) begin
                  if (motor_ok) begin
                     word     <= {cmd_steps, cmd_divider, 4'h0};
                     tx_data  <= {4'h0, cmd_motor};
                     tx_start <= ~tx_busy;
                     idx      <= '0;
                     state    <= START;
                  end else begin
                     cmd_drop <= 1'b1;
                  end
               end
            end
            START: begin
               if (tx_start) begin
                  tx_start <= 1'b0;
                  hi_cnt   <= 1'b0;
                  state    <= WAIT_HI;
               end else if (!tx_busy) begin
                  tx_start <= 1'b1;
               end
            end
            WAIT_HI: begin
               if (tx_busy || hi_cnt)
                  state <= WAIT_LO;
               else
                  hi_cnt <= 1'b1;
            end
            WAIT_LO: begin
               if (!tx_busy) begin
                  if (idx != 3'd4) begin
                     idx      <= idx + 3'd1;
                     tx_data  <= word[7:0];
                     word     <= {8'h00, word[31:8]};
                     tx_start <= 1'b1;
                     state    <= START;
                  end else begin
                     frame_sent <= 1'b1;
                     guard_cnt  <= GW'(GUARD_CYCLES);
                     state      <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Status decode and link supervision
   always_ff @(posedge CLK_SE_AR) begin
      if (rst) begin
         status  <= 10'h3ff;
         seen    <= 2'b00;
         link_up <= 1'b0;
         tmo_cnt <= '0;
         rx_err  <= 1'b0;
         rx_prev <= 1'b0;
      end else begin
         rx_prev <= rx_data_ready;
         rx_err  <= rx_edge & rx_bad;
         if (rx_valid) begin
            status  <= (status & ~upd_mask) | (flags10 & upd_mask);
            seen    <= seen_next;
            link_up <= &seen_next;
            tmo_cnt <= TW'(LINK_TIMEOUT);
         end else if (timeout_hit) begin
            status  <= 10'h3ff;
            seen    <= 2'b00;
            link_up <= 1'b0;
            tmo_cnt <= '0;
         end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
         end
      end
   end

   // Shadow map: an accept in the same cycle as a clearing status byte wins
   always_ff @(posedge CLK_SE_AR) begin
      if (rst)
         shadow <= 10'h000;
      else
         shadow <= (shadow & ~shadow_clr) | shadow_set;
   end

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_uart_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_motor_cmd_uart_master
//  Purpose  : Self-checking bench for motor_cmd_uart_master with a simple
//             transmitter model and directed status/command sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_motor_cmd_uart_master;

   localparam int GUARD    = 40;
   localparam int TMO      = 400;
   localparam int BYTE_CYC = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_motor = '0;
   logic [14:0] cmd_divider = '0;
   logic [12:0] cmd_steps = '0;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy = 1'b0;
   logic        rx_data_ready = 1'b0;
   logic [7:0]  rx_data = '0;
   logic [9:0]  pending;
   logic        link_up;
   logic        frame_sent;
   logic        cmd_drop;
   logic        rx_err;

   always #5 clk = ~clk;

   motor_cmd_uart_master #(
      .GUARD_CYCLES (GUARD),
      .LINK_TIMEOUT (TMO)
   ) dut (
      .CLK_SE_AR     (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_motor     (cmd_motor),
      .cmd_divider   (cmd_divider),
      .cmd_steps     (cmd_steps),
      .tx_data       (tx_data),
      .tx_start      (tx_start),
      .tx_busy       (tx_busy),
      .rx_data_ready (rx_data_ready),
      .rx_data       (rx_data),
      .pending       (pending),
      .link_up       (link_up),
      .frame_sent    (frame_sent),
      .cmd_drop      (cmd_drop),
      .rx_err        (rx_err)
   );

   // Transmitter model and pulse monitors
   logic [7:0] txq[$];
   int  ntx = 0, nfs = 0, ndrop = 0, nerr = 0, ncyc = 0;
   int  fall_cyc = 0, fs_cyc = 0, bcnt = 0;
   logic tx_mute = 1'b0;

   always @(negedge clk) begin
      ncyc <= ncyc + 1;
      if (frame_sent) begin nfs <= nfs + 1; fs_cyc <= ncyc; end
      if (cmd_drop) ndrop <= ndrop + 1;
      if (rx_err)   nerr  <= nerr + 1;
      if (rst) begin
         tx_busy <= 1'b0;
         bcnt    <= 0;
      end else if (tx_start) begin
         txq.push_back(tx_data);
         ntx <= ntx + 1;
         if (!tx_mute) begin tx_busy <= 1'b1; bcnt <= BYTE_CYC; end
      end else if (bcnt > 0) begin
         bcnt <= bcnt - 1;
         if (bcnt == 1) begin tx_busy <= 1'b0; fall_cyc <= ncyc; end
      end
   end

   int ncmp = 0, nfail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b; rx_data_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rx_data_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wait_frame(input int fs0, input int base, input logic [39:0] exp,
                             input string tag, input bit tchk);
      logic [7:0]  eb;
      logic [31:0] act;
      for (int k = 0; k < 500; k++) begin
         @(posedge clk);
         if (nfs != fs0) break;
      end
      #1;
      check({tag, " frame_sent"}, nfs - fs0, 1);
      check({tag, " byte count"}, txq.size() - base, 5);
      for (int i = 0; i < 5; i++) begin
         eb  = exp[8*i +: 8];
         act = (base + i < txq.size()) ? {24'h0, txq[base + i]} : 32'h100;
         check($sformatf("%s byte%0d", tag, i), act, {24'h0, eb});
      end
      if (tchk) check({tag, " frame_sent latency"}, fs_cyc - fall_cyc, 1);
   endtask

   task automatic send_cmd(input logic [3:0] m, input logic [14:0] d, input logic [12:0] s,
                           input logic [39:0] exp, input string tag, input bit tchk);
      int  base, fs0;
      bit  ok;
      base = txq.size(); fs0 = nfs; ok = 0;
      @(posedge clk); #1;
      cmd_motor = m; cmd_divider = d; cmd_steps = s; cmd_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1; break; end
      end
      check({tag, " cmd_ready"}, {31'h0, ok}, 1);
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(negedge clk);
      check({tag, " tx_start t+1"}, {31'h0, tx_start}, 1);
      check({tag, " pending t+1"}, {31'h0, pending[m]}, 1);
      wait_frame(fs0, base, exp, tag, tchk);
   endtask

   typedef struct {
      logic [7:0] b;
      logic [9:0] pend;
      logic       link;
      logic       err;
   } rxvec_t;

   rxvec_t tbl[10];

   initial begin
      int e0, n0, d0, base, fs0;
      logic [9:0] p0;

      tbl[0] = '{8'h00, 10'h3e0, 1'b0, 1'b0};
      tbl[1] = '{8'h9f, 10'h3e0, 1'b1, 1'b0};
      tbl[2] = '{8'h80, 10'h000, 1'b1, 1'b0};
      tbl[3] = '{8'h15, 10'h015, 1'b1, 1'b0};
      tbl[4] = '{8'h20, 10'h015, 1'b1, 1'b1};
      tbl[5] = '{8'h40, 10'h015, 1'b1, 1'b1};
      tbl[6] = '{8'h8a, 10'h155, 1'b1, 1'b0};
      tbl[7] = '{8'h00, 10'h140, 1'b1, 1'b0};
      tbl[8] = '{8'he0, 10'h140, 1'b1, 1'b1};
      tbl[9] = '{8'h80, 10'h000, 1'b1, 1'b0};

      // reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset tx_start",   {31'h0, tx_start}, 0);
      check("reset tx_data",    {24'h0, tx_data}, 0);
      check("reset cmd_ready",  {31'h0, cmd_ready}, 0);
      check("reset pending",    {22'h0, pending}, 32'h3ff);
      check("reset link_up",    {31'h0, link_up}, 0);
      check("reset frame_sent", {31'h0, frame_sent}, 0);
      check("reset cmd_drop",   {31'h0, cmd_drop}, 0);
      check("reset rx_err",     {31'h0, rx_err}, 0);

      // status decode table
      for (int i = 0; i < 10; i++) begin
         e0 = nerr;
         send_rx(tbl[i].b);
         check($sformatf("rx%0d pending", i), {22'h0, pending}, {22'h0, tbl[i].pend});
         check($sformatf("rx%0d link_up", i), {31'h0, link_up}, {31'h0, tbl[i].link});
         check($sformatf("rx%0d rx_err", i), nerr - e0, {31'h0, tbl[i].err});
      end

      // basic frame, then guard behaviour
      send_cmd(4'd3, 15'h00ff, 13'd6, 40'h00_30_0f_f0_03, "m3", 1'b1);
      send_rx(8'h00);
      check("guard pending[3] held", {31'h0, pending[3]}, 1);
      repeat (GUARD + 10) @(posedge clk);
      send_rx(8'h00);
      check("post-guard pending[3]", {31'h0, pending[3]}, 0);

      // status byte in the same cycle as an accept
      base = txq.size(); fs0 = nfs;
      @(posedge clk); #1;
      cmd_motor = 4'd2; cmd_divider = 15'd1; cmd_steps = 13'd1; cmd_valid = 1'b1;
      rx_data = 8'h00; rx_data_ready = 1'b1;
      @(negedge clk);
      check("same-cycle cmd_ready", {31'h0, cmd_ready}, 1);
      @(posedge clk); #1 cmd_valid = 1'b0;
      @(negedge clk);
      check("same-cycle pending[2]", {31'h0, pending[2]}, 1);
      @(posedge clk); #1 rx_data_ready = 1'b0;
      wait_frame(fs0, base, 40'h00_08_00_10_02, "m2", 1'b1);
      repeat (GUARD + 10) @(posedge clk);
      send_rx(8'h00);
      check("m2 cleared pending", {22'h0, pending}, 0);

      // extreme field values, then zero fields with a silent transmitter
      send_cmd(4'd9, 15'h7fff, 13'h1fff, 40'hff_ff_ff_f0_09, "m9", 1'b1);
      tx_mute = 1'b1;
      send_cmd(4'd0, 15'h0000, 13'h0000, 40'h00_00_00_00_00, "m0", 1'b0);
      tx_mute = 1'b0;

      // motor 7 reported busy: command must wait for the release
      send_rx(8'h84);
      check("m7 busy pending[7]", {31'h0, pending[7]}, 1);
      base = txq.size(); fs0 = nfs;
      @(posedge clk); #1;
      n0 = ntx;
      cmd_motor = 4'd7; cmd_divider = 15'h1234; cmd_steps = 13'h0abc; cmd_valid = 1'b1;
      repeat (5) @(negedge clk);
      check("m7 cmd_ready held", {31'h0, cmd_ready}, 0);
      @(posedge clk); #1;
      check("m7 no tx_start", ntx - n0, 0);
      send_rx(8'h80);
      check("m7 accepted next cycle", ntx - n0, 1);
      cmd_valid = 1'b0;
      wait_frame(fs0, base, 40'h55_e1_23_40_07, "m7", 1'b1);

      // out-of-range motor is dropped
      @(posedge clk); #1;
      n0 = ntx; d0 = ndrop;
      cmd_motor = 4'd12; cmd_valid = 1'b1;
      @(negedge clk);
      check("m12 cmd_ready", {31'h0, cmd_ready}, 1);
      @(posedge clk); #1 cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("m12 cmd_drop", ndrop - d0, 1);
      check("m12 no tx_start", ntx - n0, 0);
      check("m12 fsm idle", {31'h0, cmd_ready}, 1);

      // malformed byte, then link timeout
      p0 = pending; e0 = nerr;
      send_rx(8'h20);
      check("err byte rx_err", nerr - e0, 1);
      check("err byte pending", {22'h0, pending}, {22'h0, p0});
      repeat (TMO + 20) @(posedge clk);
      #1;
      check("timeout link_up", {31'h0, link_up}, 0);
      check("timeout pending", {22'h0, pending}, 32'h3ff);
      check("timeout cmd_ready", {31'h0, cmd_ready}, 0);

      // reset in the middle of a frame
      send_rx(8'h00);
      send_rx(8'h80);
      check("relink link_up", {31'h0, link_up}, 1);
      check("relink pending", {22'h0, pending}, 0);
      fs0 = nfs;
      @(posedge clk); #1;
      n0 = ntx;
      cmd_motor = 4'd1; cmd_divider = 15'd5; cmd_steps = 13'd5; cmd_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (cmd_ready) break;
      end
      @(posedge clk); #1 cmd_valid = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         if (ntx - n0 >= 3) break;
      end
      #1;
      check("rst-mid byte2 started", ntx - n0, 3);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst-mid tx_start",   {31'h0, tx_start}, 0);
      check("rst-mid tx_data",    {24'h0, tx_data}, 0);
      check("rst-mid pending",    {22'h0, pending}, 32'h3ff);
      check("rst-mid link_up",    {31'h0, link_up}, 0);
      check("rst-mid cmd_ready",  {31'h0, cmd_ready}, 0);
      rst = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      check("rst-mid no frame_sent", nfs - fs0, 0);
      check("rst-mid no more bytes", ntx - n0, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
`default_nettype wire
